// File: rtl/traffic_pkg.sv
// Shared definitions for the countdown display: segment patterns, digit codes,
// scan-state encoding and the constant-divisor BCD split.
package traffic_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit codes beyond 0..9 understood by the decoder
  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    GAP_U = 2'd1,
    TENS  = 2'd2,
    GAP_T = 2'd3
  } scan_state_t;

  // Input range is 0..31, so three compares replace a divider
  function automatic logic [3:0] bcd_tens(input logic [4:0] v);
    logic [3:0] t;
    if (v >= 5'd30)      t = 4'd3;
    else if (v >= 5'd20) t = 4'd2;
    else if (v >= 5'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] bcd_units(input logic [4:0] v);
    logic [4:0] t10;
    logic [4:0] diff;
    t10  = 5'(bcd_tens(v) * 4'd10);
    diff = v - t10;
    return diff[3:0];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to 7-segment decoder (active-high, gfedcba).
// Codes 0..9 are digits, CODE_DASH is a centre bar, anything else is blank.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:      o_seg = SEG_0;
      4'd1:      o_seg = SEG_1;
      4'd2:      o_seg = SEG_2;
      4'd3:      o_seg = SEG_3;
      4'd4:      o_seg = SEG_4;
      4'd5:      o_seg = SEG_5;
      4'd6:      o_seg = SEG_6;
      4'd7:      o_seg = SEG_7;
      4'd8:      o_seg = SEG_8;
      4'd9:      o_seg = SEG_9;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// Two-digit multiplexed countdown display with leading-zero blanking, final-
// seconds blink, offline dashes and a registered copy of the lamp pattern.
module countdown_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int GAP_CYC        = 2,
  parameter int BLINK_DIV      = 32,
  parameter int BLINK_THRESH   = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] countdown_time,
  input  logic [5:0] led_light,
  input  logic       online,
  output logic [6:0] seg_out,
  output logic [1:0] an_out,
  output logic [5:0] led_out
);

  localparam int SLOT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int SW       = $clog2(SLOT_MAX + 1);
  localparam int BW       = $clog2(BLINK_DIV + 1);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GAP_LAST   = SW'(GAP_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    THRESH     = 5'(BLINK_THRESH);
  localparam logic [6:0]    SEG_RESET  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  // Input stage
  logic [4:0] r_val;
  logic [5:0] r_led;
  logic       r_online;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val    <= '0;
      r_led    <= '0;
      r_online <= 1'b0;
    end else begin
      r_val    <= countdown_time;
      r_led    <= led_light;
      r_online <= online;
    end
  end

  assign led_out = r_led;

  logic [3:0] w_tens;
  logic [3:0] w_units;

  assign w_tens  = bcd_tens(r_val);
  assign w_units = bcd_units(r_val);

  // Scan FSM
  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GAP_T;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    case (r_state)
      UNITS:   if (r_cnt == SCAN_LAST) w_state_next = GAP_U;
      GAP_U:   if (r_cnt == GAP_LAST)  w_state_next = TENS;
      TENS:    if (r_cnt == SCAN_LAST) w_state_next = GAP_T;
      GAP_T:   if (r_cnt == GAP_LAST)  w_state_next = UNITS;
      default: w_state_next = GAP_T;
    endcase
    if (w_state_next != r_state) w_cnt_next = '0;
  end

  // Digit code is captured on entry to a lit slot and held for the slot
  logic [3:0] r_code;
  logic [3:0] w_code_next;
  logic [3:0] w_sample;
  logic       w_entry;
  logic       w_next_lit_slot;

  assign w_next_lit_slot = (w_state_next == UNITS) || (w_state_next == TENS);

  always_comb begin
    w_sample = CODE_BLANK;
    if (!r_online)                 w_sample = CODE_DASH;
    else if (w_state_next == UNITS) w_sample = w_units;
    else if (w_tens != 4'd0)       w_sample = w_tens;
    w_entry     = (w_state_next != r_state) && w_next_lit_slot;
    w_code_next = w_entry ? w_sample : r_code;
  end

  always_ff @(posedge clk) begin
    if (rst) r_code <= CODE_BLANK;
    else     r_code <= w_code_next;
  end

  // Blink phase; a new value restarts the half-period lit
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_next;
  logic          r_phase;
  logic          w_phase_next;
  logic          w_blink_act;

  assign w_blink_act = r_online && (r_val != 5'd0) && (r_val <= THRESH);

  always_comb begin
    w_bcnt_next  = r_bcnt + 1'b1;
    w_phase_next = r_phase;
    if ((countdown_time != r_val) || !w_blink_act) begin
      w_bcnt_next  = '0;
      w_phase_next = 1'b1;
    end else if (r_bcnt == BLINK_LAST) begin
      w_bcnt_next  = '0;
      w_phase_next = ~r_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else begin
      r_bcnt  <= w_bcnt_next;
      r_phase <= w_phase_next;
    end
  end

  // Outputs follow the next state so anodes and segments switch together
  logic       w_lit;
  logic [1:0] w_an_next;
  logic [3:0] w_dec_code;
  logic [6:0] w_seg;
  logic [6:0] r_seg;
  logic [1:0] r_an;

  always_comb begin
    w_lit      = w_next_lit_slot && (w_code_next != CODE_BLANK) && w_phase_next;
    w_an_next  = 2'b00;
    w_dec_code = CODE_BLANK;
    if (w_lit) begin
      w_an_next  = (w_state_next == UNITS) ? 2'b01 : 2'b10;
      w_dec_code = w_code_next;
    end
  end

  seg7_decoder u_dec (
    .i_code (w_dec_code),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_RESET;
      r_an  <= 2'b00;
    end else begin
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
      r_an  <= w_an_next;
    end
  end

  assign seg_out = r_seg;
  assign an_out  = r_an;

endmodule

// File: tb/tb_countdown_display.sv
// Directed scoreboard bench for countdown_display: expected anode/segment/lamp
// values are queued per cycle as stimulus is planned, then checked cycle by cycle.
module tb_countdown_display;

  localparam int SCAN = 16;
  localparam int GAP  = 2;
  localparam int BDIV = 32;
  localparam int THR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] countdown_time;
  logic [5:0] led_light;
  logic       online;
  logic [6:0] seg_out;
  logic [1:0] an_out;
  logic [5:0] led_out;

  always #5 clk = ~clk;

  countdown_display #(
    .SCAN_DIV       (SCAN),
    .GAP_CYC        (GAP),
    .BLINK_DIV      (BDIV),
    .BLINK_THRESH   (THR),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .countdown_time (countdown_time),
    .led_light      (led_light),
    .online         (online),
    .seg_out        (seg_out),
    .an_out         (an_out),
    .led_out        (led_out)
  );

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic [5:0] led;
    int         t;
  } exp_t;

  exp_t       sb[$];
  int         t_push      = 0;
  int         vectors     = 0;
  int         miscompares = 0;
  bit         blink_en    = 1'b0;
  int         blink_org   = 0;
  logic [5:0] exp_led     = 6'd0;

  // Queue n cycles of an expected display; blink OFF half-periods blank it
  task automatic push(input logic [1:0] an, input logic [6:0] seg, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an  = an;
      e.seg = seg;
      e.led = exp_led;
      e.t   = t_push;
      if (blink_en && ((((t_push - blink_org) / BDIV) % 2) == 1)) begin
        e.an  = 2'b00;
        e.seg = 7'h00;
      end
      sb.push_back(e);
      t_push++;
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   n0;
    int   cnt;
    n0  = miscompares;
    cnt = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      cnt++;
      assert (an_out === e.an && seg_out === e.seg && led_out === e.led) else begin
        miscompares++;
        $error("FAIL %s t=%0d an/seg/led got %b/%h/%b expected %b/%h/%b",
               tag, e.t, an_out, seg_out, led_out, e.an, e.seg, e.led);
      end
    end
    $display("txn %s cycles=%0d errors=%0d", tag, cnt, miscompares - n0);
  endtask

  // New value takes effect at the next edge, which is cycle t_push
  task automatic set_value(input logic [4:0] nv, input bit non);
    if (nv != countdown_time) blink_org = t_push;
    blink_en       = non && (nv >= 5'd1) && (nv <= 5'(THR));
    countdown_time = nv;
    online         = non;
  endtask

  // One full scan period; inputs change halfway through the tens slot
  task automatic period(input logic [1:0] ua, input logic [6:0] us,
                        input logic [1:0] ta, input logic [6:0] ts,
                        input logic [4:0] nv, input bit non, input string tag);
    push(ua, us, SCAN);
    push(2'b00, 7'h00, GAP);
    push(ta, ts, SCAN / 2);
    drain(tag);
    set_value(nv, non);
    push(ta, ts, SCAN - SCAN / 2);
    push(2'b00, 7'h00, GAP);
    drain(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    countdown_time = 5'd25;
    led_light      = 6'd0;
    online         = 1'b1;

    // Reset state, then first UNITS slot GAP_CYC cycles later
    t_push = 0;
    push(2'b00, 7'h00, 1);
    drain("reset");
    rst = 1'b0;
    push(2'b00, 7'h00, 1);
    drain("gap0");

    period(2'b01, 7'h6D, 2'b10, 7'h5B, 5'd25, 1'b1, "P1_25");

    // 25 -> 24 mid-UNITS: current slot keeps 5, next UNITS shows 4
    push(2'b01, 7'h6D, 3);
    drain("P2_mid");
    set_value(5'd24, 1'b1);
    push(2'b01, 7'h6D, SCAN - 3);
    push(2'b00, 7'h00, GAP);
    push(2'b10, 7'h5B, SCAN);
    push(2'b00, 7'h00, GAP);
    drain("P2_rest");

    period(2'b01, 7'h66, 2'b10, 7'h5B, 5'd7, 1'b1, "P3_24");
    period(2'b01, 7'h07, 2'b00, 7'h00, 5'd0, 1'b1, "P4_7");
    period(2'b01, 7'h3F, 2'b00, 7'h00, 5'd0, 1'b0, "P5_0");
    period(2'b01, 7'h40, 2'b10, 7'h40, 5'd3, 1'b1, "P6_off");
    period(2'b01, 7'h4F, 2'b00, 7'h00, 5'd3, 1'b1, "P7_3");

    // Step 3 -> 2 during the blink OFF phase: lit again at once
    push(2'b01, 7'h4F, SCAN / 2);
    drain("P8_off");
    set_value(5'd2, 1'b1);
    push(2'b01, 7'h4F, SCAN - SCAN / 2);
    push(2'b00, 7'h00, GAP);
    push(2'b00, 7'h00, SCAN);
    push(2'b00, 7'h00, GAP);
    drain("P8_step");

    period(2'b01, 7'h5B, 2'b00, 7'h00, 5'd0, 1'b1, "P9_2");

    // Lamp pattern: not yet visible, then visible one edge later
    led_light = 6'b100001;
    vectors++;
    assert (led_out === exp_led) else begin
      miscompares++;
      $error("FAIL led_latency got %b expected %b", led_out, exp_led);
    end
    exp_led = 6'b100001;
    period(2'b01, 7'h3F, 2'b00, 7'h00, 5'd0, 1'b1, "P10_0");

    // Reset in the middle of TENS, then restart at UNITS
    push(2'b01, 7'h3F, SCAN);
    push(2'b00, 7'h00, GAP);
    push(2'b00, 7'h00, SCAN / 2);
    drain("P11_pre");
    rst     = 1'b1;
    t_push  = 0;
    exp_led = 6'd0;
    push(2'b00, 7'h00, 1);
    drain("rst_mid");
    rst     = 1'b0;
    exp_led = 6'b100001;
    push(2'b00, 7'h00, 1);
    drain("gap1");
    period(2'b01, 7'h3F, 2'b00, 7'h00, 5'd25, 1'b1, "P12_0");

    led_light = 6'b010110;
    exp_led   = 6'b010110;
    period(2'b01, 7'h6D, 2'b10, 7'h5B, 5'd25, 1'b1, "P13_25");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
